// File: rtl/serial_sub_pkg.sv
// Purpose: shared FSM state encoding and width helper for the bit-serial subtractor.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bits needed to count 0 .. n-1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_subtractor_half_subtractor.sv
// Purpose: half-subtractor cell, d = x - y with borrow out (inverse of the half adder).
// Latency: combinational, zero cycles.
// Backpressure: none; pure logic.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  assign d  = x ^ y;
  assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Purpose: bit-serial WIDTH-bit subtractor diff = a - b, LSB first, one bit per clock;
//          optional signed-overflow output ovf when SERIAL_SUB_OVF_EN is defined.
// Latency: WIDTH busy cycles after the accept edge, then a one-cycle done pulse (WIDTH+2 per op incl. IDLE).
// Backpressure: start is only honoured in IDLE; starts seen while busy or in DONE are dropped, not queued.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             borrow_out
);

  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             borrow_out_q, borrow_out_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             hs0_d, hs0_bo, hs1_bo;
  logic             bit_d, bit_bo;
  logic [WIDTH-1:0] res_cat;

`ifdef SERIAL_SUB_OVF_EN
  logic am_q, am_d;
  logic bm_q, bm_d;
  logic ovf_q, ovf_d;
`endif

  // Full-subtract cell: two half subtractors chained through the running borrow.
  half_subtractor u_hs0 (
    .x  (sa_q[0]),
    .y  (sb_q[0]),
    .d  (hs0_d),
    .bo (hs0_bo)
  );

  half_subtractor u_hs1 (
    .x  (hs0_d),
    .y  (borrow_q),
    .d  (bit_d),
    .bo (hs1_bo)
  );

  assign bit_bo = hs0_bo | hs1_bo;

  // New result bit enters from the MSB; the low WIDTH-1 bits are the ones already produced.
  assign res_cat = {bit_d, res_q};

  // State register and datapath flops; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sa_q         <= '0;
      sb_q         <= '0;
      res_q        <= '0;
      diff_q       <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
      cnt_q        <= '0;
`ifdef SERIAL_SUB_OVF_EN
      am_q         <= 1'b0;
      bm_q         <= 1'b0;
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sa_q         <= sa_d;
      sb_q         <= sb_d;
      res_q        <= res_d;
      diff_q       <= diff_d;
      borrow_q     <= borrow_d;
      borrow_out_q <= borrow_out_d;
      cnt_q        <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
      am_q         <= am_d;
      bm_q         <= bm_d;
      ovf_q        <= ovf_d;
`endif
    end
  end

  // Next-state logic: WIDTH shift cycles, then one DONE cycle back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == CNT_LAST) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath: load operands on accept, shift one bit per SHIFT cycle, publish on the last bit.
  always_comb begin
    sa_d         = sa_q;
    sb_d         = sb_q;
    res_d        = res_q;
    diff_d       = diff_q;
    borrow_d     = borrow_q;
    borrow_out_d = borrow_out_q;
    cnt_d        = cnt_q;
`ifdef SERIAL_SUB_OVF_EN
    am_d         = am_q;
    bm_d         = bm_q;
    ovf_d        = ovf_q;
`endif
    if (state_q == ST_IDLE && start) begin
      sa_d     = a;
      sb_d     = b;
      borrow_d = 1'b0;
      cnt_d    = '0;
`ifdef SERIAL_SUB_OVF_EN
      am_d     = a[WIDTH-1];
      bm_d     = b[WIDTH-1];
`endif
    end else if (state_q == ST_SHIFT) begin
      sa_d     = sa_q >> 1;
      sb_d     = sb_q >> 1;
      res_d    = res_cat[WIDTH-1:1];
      borrow_d = bit_bo;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CNT_LAST) begin
        diff_d       = res_cat;
        borrow_out_d = bit_bo;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d        = (am_q ^ bm_q) & (am_q ^ bit_d);
`endif
      end
    end
  end

  // Moore outputs decoded from state; results come straight from the hold registers.
  always_comb begin
    busy       = (state_q == ST_SHIFT);
    done       = (state_q == ST_DONE);
    diff       = diff_q;
    borrow_out = borrow_out_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf        = ovf_q;
`endif
  end

endmodule
